// File: rtl/corner_coord_packer.sv
// Raster position tracker and border filter for NMS corner flags; queues surviving
// corner coordinates plus an end-of-frame marker in a FWFT FIFO drained over valid/ready.
module corner_coord_packer #(
    parameter int RES_X  = 320,
    parameter int RES_Y  = 240,
    parameter int BORDER = 6,
    parameter int DEPTH  = 64,
    parameter int X_W    = $clog2(RES_X),
    parameter int Y_W    = $clog2(RES_Y)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_is_corner,
    input  logic           i_v,
    input  logic           i_sof,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_last,
    output logic           o_valid,
    input  logic           i_ready,
    output logic           o_overflow,
    output logic [15:0]    o_corner_cnt
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [X_W-1:0] X_LAST = X_W'(RES_X - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(RES_Y - 1);
    localparam logic [X_W-1:0] X_LO   = X_W'(BORDER);
    localparam logic [X_W-1:0] X_HI   = X_W'(RES_X - BORDER);
    localparam logic [Y_W-1:0] Y_LO   = Y_W'(BORDER);
    localparam logic [Y_W-1:0] Y_HI   = Y_W'(RES_Y - BORDER);

    typedef struct packed {
        logic           last;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } entry_t;

    // x_cnt/y_cnt hold the position the next valid sample will take.
    logic [X_W-1:0] x_cnt, s_x, r_x;
    logic [Y_W-1:0] y_cnt, s_y, r_y;
    logic           s_end, s_int;
    logic           r_corner, r_end, r_sof;

    always_comb begin
        s_x   = i_sof ? '0 : x_cnt;
        s_y   = i_sof ? '0 : y_cnt;
        s_end = (s_x == X_LAST) && (s_y == Y_LAST);
        s_int = (s_x >= X_LO) && (s_x < X_HI) && (s_y >= Y_LO) && (s_y < Y_HI);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (i_v) begin
            if (s_x == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (s_y == Y_LAST) ? '0 : s_y + 1'b1;
            end else begin
                x_cnt <= s_x + 1'b1;
                y_cnt <= s_y;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_corner <= 1'b0;
            r_end    <= 1'b0;
            r_sof    <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            r_corner <= i_v & i_is_corner & s_int;
            r_end    <= i_v & s_end;
            r_sof    <= i_v & i_sof;
            r_x      <= s_x;
            r_y      <= s_y;
        end
    end

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW:0]     wr_ptr, rd_ptr, fill, fill_c;
    logic [AW-1:0]   m_idx;
    logic            push_c, push_m, pop;

    // One slot is held back from corners so the frame marker can always land.
    always_comb begin
        fill    = wr_ptr - rd_ptr;
        push_c  = r_corner && (fill < (AW+1)'(DEPTH - 1));
        fill_c  = fill + {{AW{1'b0}}, push_c};
        push_m  = r_end && (fill_c < (AW+1)'(DEPTH));
        m_idx   = wr_ptr[AW-1:0] + {{(AW-1){1'b0}}, push_c};
        o_valid = (fill != '0);
        pop     = o_valid & i_ready;
        head    = mem[rd_ptr[AW-1:0]];
        o_x     = o_valid ? head.x    : '0;
        o_y     = o_valid ? head.y    : '0;
        o_last  = o_valid ? head.last : 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (push_c) mem[wr_ptr[AW-1:0]] <= '{last: 1'b0, x: r_x, y: r_y};
        if (push_m) mem[m_idx]          <= '{last: 1'b1, x: '0, y: '0};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_overflow   <= 1'b0;
            o_corner_cnt <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, push_c} + {{AW{1'b0}}, push_m};
            rd_ptr <= rd_ptr + {{AW{1'b0}}, pop};
            if ((r_corner && !push_c) || (r_end && !push_m))
                o_overflow <= 1'b1;
            if (r_sof)
                o_corner_cnt <= push_c ? 16'd1 : 16'd0;
            else if (push_c && (o_corner_cnt != 16'hFFFF))
                o_corner_cnt <= o_corner_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_corner_coord_packer.sv
// Directed bench for corner_coord_packer on a 16x8 frame: a scoreboard queue holds
// hand-computed entries and a negedge monitor checks every accepted head entry.
module tb_corner_coord_packer;
    localparam int RES_X = 16, RES_Y = 8, BORDER = 3, DEPTH = 8;
    localparam int X_W = 4, Y_W = 3;

    logic           i_clk = 1'b0;
    logic           i_rst_n = 1'b0;
    logic           i_is_corner = 1'b0, i_v = 1'b0, i_sof = 1'b0, i_ready = 1'b1;
    logic [X_W-1:0] o_x;
    logic [Y_W-1:0] o_y;
    logic           o_last, o_valid, o_overflow;
    logic [15:0]    o_corner_cnt;

    corner_coord_packer #(.RES_X(RES_X), .RES_Y(RES_Y), .BORDER(BORDER), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_is_corner(i_is_corner), .i_v(i_v), .i_sof(i_sof),
        .o_x(o_x), .o_y(o_y), .o_last(o_last), .o_valid(o_valid), .i_ready(i_ready),
        .o_overflow(o_overflow), .o_corner_cnt(o_corner_cnt)
    );

    always #5 i_clk = ~i_clk;

    int total = 0, bad = 0;
    logic [X_W+Y_W:0] sb[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_entry(input bit last, input int x, input int y);
        sb.push_back({last, X_W'(x), Y_W'(y)});
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_entry: got last=%0d x=%0d y=%0d expected none", o_last, o_x, o_y);
            end else begin
                logic [X_W+Y_W:0] e;
                e = sb.pop_front();
                chk("entry_last", o_last, e[X_W+Y_W]);
                chk("entry_x", o_x, e[X_W+Y_W-1:Y_W]);
                chk("entry_y", o_y, e[Y_W-1:0]);
            end
        end
    end

    task automatic px(input bit c, input bit s);
        i_v = 1'b1; i_sof = s; i_is_corner = c;
        @(posedge i_clk); #1;
        i_v = 1'b0; i_sof = 1'b0; i_is_corner = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while ((sb.size() != 0 || o_valid) && n < 300) begin
            @(posedge i_clk); #1; n++;
        end
        chk(name, int'(n < 300), 1);
        chk({name, "_sb"}, sb.size(), 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", o_valid, 0);
        chk("rst_x", o_x, 0);
        chk("rst_y", o_y, 0);
        chk("rst_last", o_last, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_cnt", o_corner_cnt, 0);
        @(posedge i_clk); #1; i_rst_n = 1'b1;
        idle(2);

        // Single interior corner at (5,4), checking two-cycle latency
        expect_entry(0, 5, 4);
        expect_entry(1, 0, 0);
        for (int i = 0; i < 128; i++) begin
            px(i == 69, i == 0);
            if (i == 69) chk("lat_c1_valid", o_valid, 0);
            if (i == 70) begin
                chk("lat_c2_valid", o_valid, 1);
                chk("lat_c2_x", o_x, 5);
                chk("lat_c2_y", o_y, 4);
            end
        end
        idle(3);
        wait_empty("frame1_drain");
        chk("frame1_cnt", o_corner_cnt, 1);
        chk("frame1_ovf", o_overflow, 0);

        // Border: only (3,3) and (12,4) lie inside x in [3,13), y in [3,5)
        expect_entry(0, 3, 3);
        expect_entry(0, 12, 4);
        expect_entry(1, 0, 0);
        for (int i = 0; i < 128; i++)
            px(i == 4*16+2 || i == 4*16+13 || i == 2*16+5 || i == 5*16+5 ||
               i == 3*16+3 || i == 4*16+12 || i == 3*16+2 || i == 2*16+3, i == 0);
        idle(3);
        wait_empty("border_drain");
        chk("border_cnt", o_corner_cnt, 2);
        chk("border_ovf", o_overflow, 0);

        // Backpressure: 10 corners at (3..12,3), only 7 fit, marker takes slot 8
        i_ready = 1'b0;
        for (int x = 3; x <= 9; x++) expect_entry(0, x, 3);
        expect_entry(1, 0, 0);
        for (int i = 0; i < 128; i++) begin
            px(i >= 51 && i <= 60, i == 0);
            if (i >= 53 && i <= 58) begin
                chk("hold_x", o_x, 3);
                chk("hold_y", o_y, 3);
                chk("hold_last", o_last, 0);
            end
        end
        idle(3);
        chk("bp_ovf", o_overflow, 1);
        chk("bp_cnt", o_corner_cnt, 7);
        chk("bp_head_valid", o_valid, 1);
        chk("bp_head_x", o_x, 3);
        i_ready = 1'b1;
        wait_empty("bp_drain");
        chk("bp_ovf_sticky", o_overflow, 1);

        // Gaps and mid-frame sof: corner at (4,3), then sof restart and corner at (5,4)
        expect_entry(0, 4, 3);
        expect_entry(0, 5, 4);
        expect_entry(1, 0, 0);
        for (int n = 0; n < 60 + 128; n++) begin
            px(n == 52 || n == 60 + 69, n == 0 || n == 60);
            idle(1);
            if (n == 59) chk("gap_cnt_before_sof", o_corner_cnt, 1);
            if (n == 60) chk("gap_cnt_after_sof", o_corner_cnt, 0);
        end
        idle(3);
        wait_empty("gap_drain");
        chk("gap_cnt_end", o_corner_cnt, 1);

        // Asynchronous reset with 3 entries queued
        i_ready = 1'b0;
        for (int i = 0; i < 54; i++) px(i >= 51 && i <= 53, i == 0);
        idle(2);
        chk("prerst_valid", o_valid, 1);
        chk("prerst_cnt", o_corner_cnt, 3);
        #2 i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_ovf", o_overflow, 0);
        chk("midrst_cnt", o_corner_cnt, 0);
        chk("midrst_x", o_x, 0);
        @(posedge i_clk); #1; i_rst_n = 1'b1;
        i_ready = 1'b1;
        idle(2);
        expect_entry(0, 5, 4);
        expect_entry(1, 0, 0);
        for (int i = 0; i < 128; i++) px(i == 69, i == 0);
        idle(3);
        wait_empty("postrst_drain");
        chk("postrst_cnt", o_corner_cnt, 1);
        chk("postrst_ovf", o_overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
